pwm_meter: RTL
==============

PWM_METER -- requirements
Module: pwm_meter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1048575, cycles without a rising edge before the input is declared static.
REQ-002 SHALL have port clk, input, 1, single system clock (50 MHz); all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port pwm_in, input, 1, asynchronous PWM signal under measurement.
REQ-005 SHALL have port duty_cycle, output, 7, measured duty in percent, 0..100.
REQ-006 SHALL have port period, output, 20, measured period in clk cycles; 0 when timed out.
REQ-007 SHALL have port valid, output, 1, one-cycle pulse when duty_cycle/period update.
REQ-008 SHALL have port timeout, output, 1, level; 1 while the input is static.

Function
REQ-009 SHALL pass pwm_in through a 2-flop synchronizer, then a third flop for edge detection; the input-to-edge latency is 3 cycles.
REQ-010 SHALL use states IDLE (awaiting first rising edge), MEASURE (counting) and DIVIDE (computing duty).
REQ-011 SHALL count period_cnt (20 bit, saturating at 2^20-1) in every cycle since the last rising edge, and high_cnt (20 bit, saturating) in cycles where the synchronized input is 1.
REQ-012 SHALL, on a rising edge in MEASURE, capture period_cnt and high_cnt, restart both counters at 1 and 1 in that cycle, and enter DIVIDE.
REQ-013 SHALL, on the first rising edge in IDLE, restart the counters and enter MEASURE without producing an output.
REQ-014 SHALL compute duty = floor((high*100 + period/2) / period) with a 27-bit dividend and a restoring divider retiring 1 bit per cycle.
REQ-015 SHALL clamp the duty result to 100.
REQ-016 SHALL update duty_cycle and period and pulse valid exactly 28 cycles after the capture cycle, then return to MEASURE.
REQ-017 SHALL keep counting in DIVIDE; a rising edge during DIVIDE restarts the counters, but that capture is discarded and DIVIDE is not restarted.
REQ-018 SHALL, when period_cnt reaches TIMEOUT in any state, set duty_cycle to 100 if the synchronized input is 1 and to 0 otherwise, set period to 0, pulse valid once, assert timeout, and enter IDLE.
REQ-019 SHALL deassert timeout on the next rising edge; the first full period after that rising edge produces the next result.
REQ-020 SHALL hold duty_cycle, period and timeout stable between valid pulses.

Reset
REQ-021 SHALL, while rst=1, force state to IDLE, clear all counters and synchronizer flops, and drive duty_cycle=0, period=0, valid=0, timeout=0.
REQ-022 SHALL, on reset asserted during DIVIDE, abort the division and emit no valid pulse.
REQ-023 SHALL ignore edges on pwm_in in the first 3 cycles after reset release (synchronizer refill).

Configuration
REQ-024 SHALL, with PWM_METER_FILTER_EN defined, insert a glitch filter after the synchronizer that changes the filtered level only after 4 consecutive equal samples; this adds 4 cycles of edge latency and ignores pulses shorter than 4 cycles.
REQ-025 SHALL, without PWM_METER_FILTER_EN, drive edge detection and high counting directly from the synchronized input.

Verification
REQ-026 Bench SHALL cover: period 1000, high 500, repeated -> from the second measured period, valid pulses with duty_cycle=50, period=1000.
REQ-027 Bench SHALL cover: period 524288, high 262187 -> duty_cycle=50, period=524288.
REQ-028 Bench SHALL cover: period 200, high 1 -> duty_cycle=1 (round half up); then period 200, high 200 -> clamped to 100.
REQ-029 Bench SHALL cover: pwm_in held 0 for 1048575 cycles after activity -> one valid pulse, duty_cycle=0, period=0, timeout=1; held 1 instead -> duty_cycle=100.
REQ-030 Bench SHALL cover: rst pulsed 10 cycles after a capture -> no valid pulse, all outputs 0, state IDLE.
REQ-031 Bench SHALL cover, with PWM_METER_FILTER_EN: 2-cycle glitches on a period-1000/high-300 signal -> duty_cycle=30, period=1000.

Source files
------------

// File: rtl/pwm_meter.sv
// pwm_meter: measures the period and the duty cycle of an asynchronous PWM input.
//
// Ports
//   clk        : system clock; all logic runs on its rising edge
//   rst        : synchronous active-high reset
//   pwm_in     : asynchronous PWM input under measurement
//   duty_cycle : measured duty in percent, 0..100
//   period     : measured period in clk cycles; 0 after a timeout
//   valid      : one-cycle pulse whenever duty_cycle/period update
//   timeout    : level, high while the input is static (no rising edge for TIMEOUT cycles)
//
// Optional feature: define PWM_METER_FILTER_EN to add a 4-sample glitch filter between the
// synchronizer and the edge detector (adds 4 cycles of edge latency, rejects pulses < 4 cycles).
module pwm_meter #(
  parameter int unsigned TIMEOUT = 1048575
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [6:0]  duty_cycle,
  output logic [19:0] period,
  output logic        valid,
  output logic        timeout
);

  localparam logic [19:0] CntMax     = 20'hFFFFF;
  localparam logic [19:0] TimeoutCnt = 20'(TIMEOUT);
  localparam logic [4:0]  DivSteps   = 5'd27;
`ifdef PWM_METER_FILTER_EN
  // Refill time covers the synchronizer plus the filter.
  localparam logic [2:0]  BlankCycles = 3'd7;
`else
  localparam logic [2:0]  BlankCycles = 3'd3;
`endif

  typedef enum logic [1:0] {StIdle, StMeasure, StDivide} state_e;

  state_e       state_q, state_d;
  logic         sync1_q, sync2_q;
  logic         level, level_q;
  logic [2:0]   blank_q;
  logic         rise;
  logic [19:0]  period_cnt_q, high_cnt_q;
  logic         to_hit;
  logic         capture;
  logic [26:0]  dividend;
  logic [26:0]  quo_q;
  logic [19:0]  rem_q;
  logic [19:0]  divisor_q;
  logic [4:0]   div_cnt_q;
  logic [20:0]  rem_sh;
  logic         rem_ge;
  logic [6:0]   duty_q;
  logic [19:0]  period_q;
  logic         valid_q, timeout_q;

  // Two-flop synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_METER_FILTER_EN
  logic       filt_q;
  logic [1:0] filt_cnt_q;

  // The filtered level follows the synchronized input only after 4 consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b0;
      filt_cnt_q <= 2'd0;
    end else if (sync2_q == filt_q) begin
      filt_cnt_q <= 2'd0;
    end else if (filt_cnt_q == 2'd3) begin
      filt_q     <= sync2_q;
      filt_cnt_q <= 2'd0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 2'd1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Edge-detect flop plus a blanking counter that hides the refill after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      blank_q <= 3'd0;
    end else begin
      level_q <= level;
      if (blank_q != BlankCycles) blank_q <= blank_q + 3'd1;
    end
  end

  assign rise = level && !level_q && (blank_q == BlankCycles);

  // Period and high-time counters; both restart at 1 so the rising-edge cycle itself counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt_q <= 20'd0;
      high_cnt_q   <= 20'd0;
    end else if (rise) begin
      period_cnt_q <= 20'd1;
      high_cnt_q   <= 20'd1;
    end else begin
      if (period_cnt_q != CntMax) period_cnt_q <= period_cnt_q + 20'd1;
      if (level && (high_cnt_q != CntMax)) high_cnt_q <= high_cnt_q + 20'd1;
    end
  end

  // Fires once per static stretch; a rising edge re-arms it.
  assign to_hit  = !timeout_q && (period_cnt_q >= TimeoutCnt) && !rise;
  assign capture = (state_q == StMeasure) && rise;

  // Rounded dividend: high*100 + period/2 fits in 27 bits for 20-bit counts.
  assign dividend = 27'(high_cnt_q) * 27'd100 + 27'(period_cnt_q[19:1]);

  // One restoring-division step.
  assign rem_sh = {rem_q, quo_q[26]};
  assign rem_ge = rem_sh >= {1'b0, divisor_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (rise) state_d = StMeasure;
      StMeasure: if (rise) state_d = StDivide;
      StDivide:  if (div_cnt_q == DivSteps) state_d = StMeasure;
      default:   state_d = StIdle;
    endcase
    if (to_hit) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q     <= 27'd0;
      rem_q     <= 20'd0;
      divisor_q <= 20'd0;
      div_cnt_q <= 5'd0;
      duty_q    <= 7'd0;
      period_q  <= 20'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (to_hit) begin
        // Static input: report the level it is stuck at; any division in flight is dropped.
        duty_q    <= level ? 7'd100 : 7'd0;
        period_q  <= 20'd0;
        valid_q   <= 1'b1;
        timeout_q <= 1'b1;
      end else begin
        if (rise) timeout_q <= 1'b0;
        if (capture) begin
          quo_q     <= dividend;
          rem_q     <= 20'd0;
          divisor_q <= period_cnt_q;
          div_cnt_q <= 5'd0;
        end else if (state_q == StDivide) begin
          if (div_cnt_q != DivSteps) begin
            rem_q     <= rem_ge ? 20'(rem_sh - {1'b0, divisor_q}) : rem_sh[19:0];
            quo_q     <= {quo_q[25:0], rem_ge};
            div_cnt_q <= div_cnt_q + 5'd1;
          end else begin
            duty_q   <= (quo_q > 27'd100) ? 7'd100 : quo_q[6:0];
            period_q <= divisor_q;
            valid_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign duty_cycle = duty_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;

endmodule
